// File: rtl/siso_pkg.sv
// Shared types and line levels for the serial frame transmitter.
package siso_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Counter width for a 0..n-1 count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/siso_frame_tx_if.sv
// Load handshake and serial line bundle for siso_frame_tx.
interface siso_frame_tx_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output data_in, load_valid,
    input  load_ready, serial_out, busy, done
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, serial_out, busy, done
  );

endinterface

// File: rtl/siso_bit_timer.sv
// Bit-period counter: bit_end marks the last clock of each CLKS_PER_BIT period.
module siso_bit_timer
  import siso_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/siso_frame_tx.sv
// Framed serial transmitter: start bit, data LSB first, optional even parity, stop bit.
module siso_frame_tx
  import siso_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic           clk,
  input  logic           rst,
  siso_frame_tx_if.slave bus
);

  localparam int unsigned IdxW = $clog2(WIDTH + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             parity_q, parity_d;
  logic             done_q, done_d;
  logic             ready;
  logic             line;
  logic             bit_end;
  logic             timer_clear;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    ready    = 1'b0;
    line     = IDLE_LEVEL;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
      end
      StStart: begin
        line = START_LEVEL;
        if (bit_end) state_d = StData;
      end
      StData: begin
        line = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        line = parity_q;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        line = STOP_LEVEL;
        if (bit_end) begin
          ready   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // An accepted word always wins: from IDLE or chained straight out of the last stop clock.
    if (ready && bus.load_valid) begin
      shift_d  = bus.data_in;
      parity_d = ^bus.data_in;
      idx_d    = '0;
      state_d  = StStart;
    end
  end

  assign timer_clear = (state_d != state_q) || (state_q == StIdle);
  assign done_d      = (state_q == StStop) && bit_end;

  siso_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      done_q   <= done_d;
    end
  end

  assign bus.load_ready = ready;
  assign bus.serial_out = line;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_siso_frame_tx.sv
// Bench for siso_frame_tx: two configurations checked every clock against a frame-timeline model.
module tb_siso_frame_tx;

  typedef struct packed {
    logic line;
    logic last;
  } ent_t;

  logic clk;
  logic rst;

  siso_frame_tx_if #(.WIDTH(8)) a_if ();
  siso_frame_tx_if #(.WIDTH(8)) b_if ();

  siso_frame_tx #(
    .WIDTH       (8),
    .CLKS_PER_BIT(4),
    .PARITY_EN   (1)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(a_if)
  );

  siso_frame_tx #(
    .WIDTH       (8),
    .CLKS_PER_BIT(1),
    .PARITY_EN   (0)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  ent_t qa[$];
  ent_t qb[$];
  bit   done_p[2];
  int   acc_cyc[2];
  int   done_cyc_a[$];
  int   done_cyc_b[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected line for every clock of one frame, built from the framing rules.
  task automatic push_frame(input int sel, input logic [7:0] w);
    int         pe, cpb, nb;
    logic [11:0] bits;
    ent_t       e;
    pe   = (sel == 0) ? 1 : 0;
    cpb  = (sel == 0) ? 4 : 1;
    nb   = 10 + pe;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = w[i];
    if (pe == 1) bits[9] = ($countones(w) % 2 == 1);
    bits[nb-1] = 1'b1;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < cpb; c++) begin
        e.line = bits[i];
        e.last = (i == nb - 1) && (c == cpb - 1);
        if (sel == 0) qa.push_back(e);
        else qb.push_back(e);
      end
    end
  endtask

  task automatic model_cycle(input int sel);
    ent_t       e;
    logic       have, x_line, x_busy, x_ready, x_done;
    logic       o_line, o_busy, o_ready, o_done, valid;
    logic [7:0] din;
    string      p;
    p = (sel == 0) ? "a" : "b";
    if (sel == 0) begin
      {o_line, o_busy, o_ready, o_done} =
        {a_if.serial_out, a_if.busy, a_if.load_ready, a_if.done};
      valid = a_if.load_valid;
      din   = a_if.data_in;
    end else begin
      {o_line, o_busy, o_ready, o_done} =
        {b_if.serial_out, b_if.busy, b_if.load_ready, b_if.done};
      valid = b_if.load_valid;
      din   = b_if.data_in;
    end
    if (!rst) begin
      if (sel == 0) qa.delete();
      else qb.delete();
      done_p[sel] = 1'b0;
    end
    have = (sel == 0) ? (qa.size() > 0) : (qb.size() > 0);
    e    = '0;
    if (have) begin
      if (sel == 0) e = qa.pop_front();
      else e = qb.pop_front();
    end
    x_line  = have ? e.line : 1'b1;
    x_busy  = have;
    x_ready = have ? e.last : 1'b1;
    x_done  = done_p[sel];
    chk({p, "_line"}, 32'(o_line), 32'(x_line));
    chk({p, "_busy"}, 32'(o_busy), 32'(x_busy));
    chk({p, "_ready"}, 32'(o_ready), 32'(x_ready));
    chk({p, "_done"}, 32'(o_done), 32'(x_done));
    if (o_done === 1'b1) begin
      if (sel == 0) done_cyc_a.push_back(cyc);
      else done_cyc_b.push_back(cyc);
    end
    done_p[sel] = have && e.last;
    if (rst && x_ready && valid) begin
      push_frame(sel, din);
      acc_cyc[sel] = cyc;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_now(input string tag);
    chk({tag, "_a_line"}, 32'(a_if.serial_out), 32'd1);
    chk({tag, "_a_busy"}, 32'(a_if.busy), 32'd0);
    chk({tag, "_a_ready"}, 32'(a_if.load_ready), 32'd1);
    chk({tag, "_a_done"}, 32'(a_if.done), 32'd0);
    chk({tag, "_b_line"}, 32'(b_if.serial_out), 32'd1);
    chk({tag, "_b_busy"}, 32'(b_if.busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    a_if.data_in = 8'h00;
    a_if.load_valid = 1'b0;
    b_if.data_in = 8'h00;
    b_if.load_valid = 1'b0;
    #1;
    chk_reset_now("por");

    // Reset held across edges while load_valid toggles: nothing may start.
    for (int i = 0; i < 4; i++) begin
      a_if.load_valid = ~a_if.load_valid;
      b_if.load_valid = ~b_if.load_valid;
      a_if.data_in = 8'($urandom);
      step();
    end
    a_if.load_valid = 1'b0;
    b_if.load_valid = 1'b0;
    rst = 1'b1;
    steps(3);

    // Single A5 frame, then idle.
    a_if.data_in = 8'hA5;
    a_if.load_valid = 1'b1;
    done_cyc_a.delete();
    step();
    a_if.load_valid = 1'b0;
    steps(50);
    chk("a5_done_count", 32'(done_cyc_a.size()), 32'd1);
    if (done_cyc_a.size() > 0) chk("a5_done_time", 32'(done_cyc_a[0] - acc_cyc[0]), 32'd45);

    // Back-to-back 01 then FF with load_valid held.
    done_cyc_a.delete();
    a_if.data_in = 8'h01;
    a_if.load_valid = 1'b1;
    step();
    a_if.data_in = 8'hFF;
    steps(44);
    a_if.load_valid = 1'b0;
    steps(50);
    chk("b2b_done_count", 32'(done_cyc_a.size()), 32'd2);
    if (done_cyc_a.size() > 1) chk("b2b_done_gap", 32'(done_cyc_a[1] - done_cyc_a[0]), 32'd44);

    // No-parity, one clock per bit: 3C.
    done_cyc_b.delete();
    b_if.data_in = 8'h3C;
    b_if.load_valid = 1'b1;
    step();
    b_if.load_valid = 1'b0;
    steps(15);
    chk("b3c_done_count", 32'(done_cyc_b.size()), 32'd1);
    if (done_cyc_b.size() > 0) chk("b3c_done_time", 32'(done_cyc_b[0] - acc_cyc[1]), 32'd11);

    // load_valid and changing data_in during a frame.
    a_if.data_in = 8'hA5;
    a_if.load_valid = 1'b1;
    step();
    a_if.data_in = 8'h00;
    steps(10);
    for (int i = 0; i < 40; i++) begin
      a_if.data_in = 8'($urandom);
      step();
    end
    a_if.load_valid = 1'b0;
    steps(50);

    // Asynchronous reset in the third data bit.
    a_if.data_in = 8'hA5;
    a_if.load_valid = 1'b1;
    step();
    a_if.load_valid = 1'b0;
    steps(13);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_now("async_rst");
    qa.delete();
    qb.delete();
    done_p[0] = 1'b0;
    done_p[1] = 1'b0;
    a_if.load_valid = 1'b1;
    steps(3);
    a_if.load_valid = 1'b0;
    rst = 1'b1;
    steps(8);
    a_if.data_in = 8'h5A;
    a_if.load_valid = 1'b1;
    step();
    a_if.load_valid = 1'b0;
    steps(50);

    // Random traffic on both configurations.
    for (int i = 0; i < 600; i++) begin
      a_if.load_valid = ($urandom_range(0, 3) == 0);
      a_if.data_in = 8'($urandom);
      b_if.load_valid = ($urandom_range(0, 2) == 0);
      b_if.data_in = 8'($urandom);
      step();
    end
    a_if.load_valid = 1'b0;
    b_if.load_valid = 1'b0;
    steps(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
